// File: rtl/pp_buf_pkg.sv
// Shared sizing helpers and fill-count bookkeeping for the ping-pong SDP buffer.
// Everything here is elaboration-time arithmetic plus one small decode.
package pp_buf_pkg;

  localparam int MIN_READ_LATENCY = 1;
  localparam int MAX_READ_LATENCY = 3;

  typedef enum logic [1:0] {
    FILL_HOLD = 2'd0,
    FILL_INC  = 2'd1,
    FILL_DEC  = 2'd2
  } fill_op_e;

  // Bank index width; a single-bit pointer is kept even for degenerate counts.
  function automatic int ptr_width(input int num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 1;
  endfunction

  function automatic int bank_addr_width(input int num_banks, input int depth);
    return $clog2(num_banks * depth);
  endfunction

  // Holds 0..num_banks inclusive.
  function automatic int count_width(input int num_banks);
    return $clog2(num_banks + 1);
  endfunction

  function automatic bit read_latency_ok(input int latency);
    return (latency >= MIN_READ_LATENCY) && (latency <= MAX_READ_LATENCY);
  endfunction

  // A bank finishing and a bank being released in the same cycle cancel out.
  function automatic fill_op_e fill_op(input logic bank_done, input logic bank_release);
    if (bank_done && !bank_release) return FILL_INC;
    if (!bank_done && bank_release) return FILL_DEC;
    return FILL_HOLD;
  endfunction

endpackage

// File: rtl/pp_sdp_buffer_sdp_ram_core.sv
// Simple dual-port RAM: one write port, one registered read port with optional
// extra output stages. Each stage only loads when its enable says a read is passing.
module sdp_ram_core #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int WORDS      = 512,
  parameter int OUT_STAGES = 1
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [OUT_STAGES:0]   stage_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [WORDS];
  logic [DATA_WIDTH-1:0] pipe [OUT_STAGES+1];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Stages hold their contents between reads so the output stays stable.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      for (int k = 0; k <= OUT_STAGES; k++) pipe[k] <= '0;
    end else begin
      if (stage_en[0]) pipe[0] <= mem[rd_addr];
      for (int k = 1; k <= OUT_STAGES; k++) begin
        if (stage_en[k]) pipe[k] <= pipe[k-1];
      end
    end
  end

  assign rd_data = pipe[OUT_STAGES];

endmodule

// File: rtl/pp_sdp_buffer.sv
// Multi-bank ping-pong buffer: a writer fills whole banks in turn, a reader
// randomly accesses the oldest full bank and releases it with rd_done.
module pp_sdp_buffer
  import pp_buf_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 256,
  parameter int NUM_BANKS    = 2,
  parameter int READ_LATENCY = 2
) (
  input  logic                     clock,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  output logic                     wr_ready,
  input  logic                     rd_req,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  input  logic                     rd_done,
  output logic                     rd_bank_valid,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     rd_valid,
  output logic                     overflow
);

  localparam int OFF_W  = $clog2(DEPTH);
  localparam int PTR_W  = ptr_width(NUM_BANKS);
  localparam int ADDR_W = bank_addr_width(NUM_BANKS, DEPTH);
  localparam int CNT_W  = count_width(NUM_BANKS);

  if (!read_latency_ok(READ_LATENCY)) begin : g_bad_read_latency
    $error("pp_sdp_buffer: READ_LATENCY must be within 1..3");
  end

  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [OFF_W-1:0]        wr_cnt;
  logic [CNT_W-1:0]        full_cnt;
  logic [READ_LATENCY-1:0] rd_vld_pipe;
  logic [READ_LATENCY-1:0] stage_en;

  logic wr_fire;
  logic wr_last;
  logic rd_fire;
  logic rd_release;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_BANKS - 1)) ? '0 : p + 1'b1;
  endfunction

  assign wr_ready      = (full_cnt < CNT_W'(NUM_BANKS));
  assign rd_bank_valid = (full_cnt != '0);

  assign wr_fire    = wr_valid && wr_ready;
  assign wr_last    = wr_fire && (wr_cnt == OFF_W'(DEPTH - 1));
  assign rd_fire    = rd_req && rd_bank_valid;
  assign rd_release = rd_done && rd_bank_valid;

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      wr_cnt      <= '0;
      full_cnt    <= '0;
      overflow    <= 1'b0;
      rd_vld_pipe <= '0;
    end else begin
      if (wr_fire) begin
        wr_cnt <= wr_last ? '0 : wr_cnt + 1'b1;
        if (wr_last) wr_ptr <= next_ptr(wr_ptr);
      end
      if (wr_valid && !wr_ready) overflow <= 1'b1;
      if (rd_release) rd_ptr <= next_ptr(rd_ptr);

      unique case (fill_op(wr_last, rd_release))
        FILL_INC: full_cnt <= full_cnt + 1'b1;
        FILL_DEC: full_cnt <= full_cnt - 1'b1;
        default:  full_cnt <= full_cnt;
      endcase

      rd_vld_pipe[0] <= rd_fire;
      for (int k = 1; k < READ_LATENCY; k++) rd_vld_pipe[k] <= rd_vld_pipe[k-1];
    end
  end

  // Stage k of the RAM read path loads when the read reaches it.
  always_comb begin
    stage_en    = rd_vld_pipe << 1;
    stage_en[0] = rd_fire;
  end

  assign rd_valid = rd_vld_pipe[READ_LATENCY-1];

  // The bank index is captured with the address at the request edge, so a
  // simultaneous rd_done still reads the bank being released.
  sdp_ram_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_W),
    .WORDS      (NUM_BANKS * DEPTH),
    .OUT_STAGES (READ_LATENCY - 1)
  ) u_ram (
    .clock    (clock),
    .rst_n    (rst_n),
    .wr_en    (wr_fire),
    .wr_addr  ({wr_ptr, wr_cnt}),
    .wr_data  (wr_data),
    .stage_en (stage_en),
    .rd_addr  ({rd_ptr, rd_addr}),
    .rd_data  (rd_data)
  );

endmodule

// File: tb/tb_pp_sdp_buffer.sv
// Directed and randomized bench for pp_sdp_buffer against a bank-count model:
// banks filled minus banks released decides readiness, reads retire after a fixed delay.
module tb_pp_sdp_buffer;

  localparam int DW  = 16;
  localparam int D   = 8;
  localparam int NB  = 2;
  localparam int LAT = 2;
  localparam int AW  = 3;

  logic          clock = 1'b0;
  logic          rst_n;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_done;
  logic          rd_bank_valid;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          overflow;

  always #5 clock = ~clock;

  pp_sdp_buffer #(
    .DATA_WIDTH   (DW),
    .DEPTH        (D),
    .NUM_BANKS    (NB),
    .READ_LATENCY (LAT)
  ) dut (
    .clock         (clock),
    .rst_n         (rst_n),
    .wr_valid      (wr_valid),
    .wr_data       (wr_data),
    .wr_ready      (wr_ready),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_done       (rd_done),
    .rd_bank_valid (rd_bank_valid),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .overflow      (overflow)
  );

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rd_item_t;

  logic [DW-1:0] m_mem [NB*D];
  int            m_completed;
  int            m_released;
  int            m_wr_off;
  int            m_cyc;
  bit            m_overflow;
  bit            m_rd_valid;
  logic [DW-1:0] m_rd_data;
  rd_item_t      m_pending[$];

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs the DUT just sampled.
  function automatic void modelEdge();
    int full;
    bit ready;
    bit bvalid;
    full   = m_completed - m_released;
    ready  = (full < NB);
    bvalid = (full != 0);
    m_cyc++;
    if (!rst_n) begin
      m_completed = 0;
      m_released  = 0;
      m_wr_off    = 0;
      m_overflow  = 0;
      m_rd_valid  = 0;
      m_rd_data   = '0;
      m_pending.delete();
      return;
    end
    if (rd_req && bvalid) begin
      rd_item_t it;
      it.due  = m_cyc + LAT - 1;
      it.data = m_mem[(m_released % NB) * D + int'(rd_addr)];
      m_pending.push_back(it);
    end
    if (wr_valid && ready) begin
      m_mem[(m_completed % NB) * D + m_wr_off] = wr_data;
      m_wr_off++;
      if (m_wr_off == D) begin
        m_wr_off = 0;
        m_completed++;
      end
    end
    if (wr_valid && !ready) m_overflow = 1;
    if (rd_done && bvalid) m_released++;
    m_rd_valid = 0;
    if (m_pending.size() > 0 && m_pending[0].due == m_cyc) begin
      m_rd_valid = 1;
      m_rd_data  = m_pending[0].data;
      void'(m_pending.pop_front());
    end
  endfunction

  task automatic checkOutput();
    checkValue("wr_ready",      32'(wr_ready),      32'((m_completed - m_released) < NB));
    checkValue("rd_bank_valid", 32'(rd_bank_valid), 32'((m_completed - m_released) != 0));
    checkValue("rd_valid",      32'(rd_valid),      32'(m_rd_valid));
    checkValue("rd_data",       32'(rd_data),       32'(m_rd_data));
    checkValue("overflow",      32'(overflow),      32'(m_overflow));
  endtask

  task automatic applyStimulus(input bit wv, input logic [DW-1:0] wd, input bit rq,
                               input logic [AW-1:0] ra, input bit rd, input bit rn = 1'b1);
    wr_valid = wv;
    wr_data  = wd;
    rd_req   = rq;
    rd_addr  = ra;
    rd_done  = rd;
    rst_n    = rn;
    @(posedge clock);
    modelEdge();
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, '0, 0, '0, 0);
  endtask

  task automatic doReset();
    applyStimulus(0, '0, 0, '0, 0, 1'b0);
  endtask

  logic [DW-1:0] got [16];
  int            n_valid;
  int            first_valid;

  initial begin
    m_completed = 0;
    m_released  = 0;
    m_wr_off    = 0;
    m_cyc       = 0;
    m_overflow  = 0;
    m_rd_valid  = 0;
    m_rd_data   = '0;

    // Reset state
    doReset();
    doReset();
    checkValue("reset_wr_ready",      32'(wr_ready),      32'd1);
    checkValue("reset_rd_bank_valid", 32'(rd_bank_valid), 32'd0);
    checkValue("reset_rd_valid",      32'(rd_valid),      32'd0);
    checkValue("reset_rd_data",       32'(rd_data),       32'd0);
    checkValue("reset_overflow",      32'(overflow),      32'd0);

    // Fill bank 0, then read it back-to-back
    for (int i = 0; i < D; i++) begin
      applyStimulus(1, DW'(i), 0, '0, 0);
      if (i == D - 2) checkValue("bank_valid_before_last", 32'(rd_bank_valid), 32'd0);
    end
    checkValue("bank_valid_after_last", 32'(rd_bank_valid), 32'd1);
    n_valid     = 0;
    first_valid = -1;
    for (int i = 0; i < D + 2; i++) begin
      if (i < D) applyStimulus(0, '0, 1, AW'(i), 0);
      else       applyStimulus(0, '0, 0, '0, 0);
      if (rd_valid) begin
        if (first_valid < 0) first_valid = i;
        got[n_valid] = rd_data;
        n_valid++;
      end
    end
    checkValue("burst_first_valid_step", 32'(first_valid), 32'd1);
    checkValue("burst_valid_count", 32'(n_valid), 32'd8);
    for (int k = 0; k < D; k++) checkValue("burst_data", 32'(got[k]), 32'(k));

    // Read addr 5 together with release of the bank
    applyStimulus(0, '0, 1, 3'd5, 1);
    checkValue("release_bank_valid", 32'(rd_bank_valid), 32'd0);
    idle(1);
    checkValue("release_read_valid", 32'(rd_valid), 32'd1);
    checkValue("release_read_data",  32'(rd_data),  32'h0005);

    // Read request with no full bank
    applyStimulus(0, '0, 1, 3'd1, 0);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      checkValue("no_bank_rd_valid", 32'(rd_valid), 32'd0);
    end

    // Bank completion coinciding with release
    doReset();
    for (int i = 0; i < D; i++) applyStimulus(1, DW'(16'h20 + i), 0, '0, 0);
    for (int i = 0; i < D - 1; i++) applyStimulus(1, DW'(16'h30 + i), 0, '0, 0);
    applyStimulus(1, 16'h37, 0, '0, 1);
    checkValue("coincide_wr_ready",   32'(wr_ready),      32'd1);
    checkValue("coincide_bank_valid", 32'(rd_bank_valid), 32'd1);
    for (int i = 0; i < D; i++) applyStimulus(0, '0, 1, AW'(i), 0);
    checkValue("coincide_first_data", 32'(rd_data), 32'h36);
    idle(1);
    checkValue("coincide_last_data", 32'(rd_data), 32'h37);
    applyStimulus(0, '0, 0, '0, 1);

    // Both banks full, then an overflowing write
    doReset();
    for (int i = 0; i < 2 * D; i++) applyStimulus(1, DW'(16'h100 + i), 0, '0, 0);
    checkValue("full_wr_ready", 32'(wr_ready), 32'd0);
    applyStimulus(1, 16'hDEAD, 0, '0, 0);
    checkValue("overflow_set", 32'(overflow), 32'd1);
    for (int i = 0; i < D; i++) applyStimulus(0, '0, 1, AW'(i), 0);
    idle(2);
    checkValue("overflow_bank0_last", 32'(rd_data), 32'h107);
    idle(2);
    checkValue("overflow_sticky", 32'(overflow), 32'd1);

    // Reset with a partial bank and a read in flight
    doReset();
    for (int i = 0; i < D; i++) applyStimulus(1, DW'(16'h40 + i), 0, '0, 0);
    applyStimulus(1, 16'h50, 0, '0, 0);
    applyStimulus(1, 16'h51, 0, '0, 0);
    applyStimulus(1, 16'h52, 1, 3'd2, 0);
    doReset();
    for (int i = 0; i < 3; i++) begin
      checkValue("inflight_rd_valid", 32'(rd_valid), 32'd0);
      if (i < 2) idle(1);
    end
    checkValue("midreset_wr_ready",   32'(wr_ready),      32'd1);
    checkValue("midreset_bank_valid", 32'(rd_bank_valid), 32'd0);
    applyStimulus(1, 16'hBEEF, 0, '0, 0);
    for (int i = 1; i < D; i++) applyStimulus(1, DW'(16'h60 + i), 0, '0, 0);
    applyStimulus(0, '0, 1, 3'd0, 0);
    idle(1);
    checkValue("landing_valid", 32'(rd_valid), 32'd1);
    checkValue("landing_word",  32'(rd_data),  32'hBEEF);
    applyStimulus(0, '0, 0, '0, 1);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      applyStimulus($urandom_range(0, 99) < 60, DW'($urandom), $urandom_range(0, 99) < 50,
                    AW'($urandom), $urandom_range(0, 99) < 12, $urandom_range(0, 299) != 0);
    end
    idle(LAT + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pp_sdp_buffer.md
PP_SDP_BUFFER -- requirements
Module: pp_sdp_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of every stored word.
REQ-002 SHALL have parameter DEPTH, default 256: words per bank, power of two, 4..4096.
REQ-003 SHALL have parameter NUM_BANKS, default 2: bank count, 2..8.
REQ-004 SHALL have parameter READ_LATENCY, default 2: rd_req-to-rd_valid cycles, 1..3.
REQ-005 SHALL have port clock  input  1: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  input  1: reset, synchronous and active-low.
REQ-007 SHALL have port wr_valid  input  1: write word offered.
REQ-008 SHALL have port wr_data  input  DATA_WIDTH: write word.
REQ-009 SHALL have port wr_ready  output  1: a bank is free for writing.
REQ-010 SHALL have port rd_req  input  1: read request.
REQ-011 SHALL have port rd_addr  input  $clog2(DEPTH): word offset in the current read bank.
REQ-012 SHALL have port rd_done  input  1: single-cycle pulse releasing the current read bank.
REQ-013 SHALL have port rd_bank_valid  output  1: a full bank is available to read.
REQ-014 SHALL have port rd_data  output  DATA_WIDTH: read word.
REQ-015 SHALL have port rd_valid  output  1: rd_data qualifier.
REQ-016 SHALL have port overflow  output  1: sticky; a write was offered while wr_ready was low.

Function
REQ-017 SHALL accept a write when wr_valid and wr_ready are both high, storing it at address wr_cnt of bank wr_ptr, then incrementing wr_cnt.
REQ-018 SHALL, on accepting word DEPTH-1, wrap wr_cnt to 0, advance wr_ptr modulo NUM_BANKS and increment full_cnt; rd_bank_valid rises the next cycle.
REQ-019 SHALL drive wr_ready = (full_cnt < NUM_BANKS) and rd_bank_valid = (full_cnt != 0), both registered-state decodes.
REQ-020 SHALL ignore wr_valid while wr_ready is low: nothing written, wr_cnt unchanged, overflow set until reset.
REQ-021 SHALL, on rd_req with rd_bank_valid high, read bank rd_ptr at rd_addr and present rd_data with rd_valid high exactly READ_LATENCY cycles later; back-to-back requests give back-to-back results.
REQ-022 SHALL ignore rd_req while rd_bank_valid is low: no rd_valid is produced.
REQ-023 SHALL, on rd_done with rd_bank_valid high, advance rd_ptr modulo NUM_BANKS and decrement full_cnt; rd_done with rd_bank_valid low is ignored.
REQ-024 SHALL leave full_cnt unchanged when bank completion (REQ-018) and rd_done coincide, with both pointers advancing.
REQ-025 SHALL latch the bank index with each accepted rd_req so that reads in flight when rd_done arrives return data from the released bank.
REQ-026 SHALL accept a rd_req and rd_done in the same cycle, the read using the pre-advance rd_ptr.
REQ-027 SHALL never read from the bank being written: a bank becomes readable only after it is full (REQ-018).
REQ-028 SHALL hold rd_data at its last value while rd_valid is low.

Reset
REQ-029 SHALL, with rst_n low at a clock edge, clear wr_ptr, rd_ptr, wr_cnt, full_cnt, overflow and all read-pipeline valid bits, and set wr_ready=1, rd_bank_valid=0, rd_valid=0, rd_data=0.
REQ-030 SHALL discard in-flight reads and partially written banks on reset mid-operation; memory contents are not cleared.

Structure
REQ-031 SHALL place the pointer width, bank address width ($clog2(NUM_BANKS*DEPTH)) and the READ_LATENCY range check in the shared package pp_buf_pkg.
REQ-032 SHALL instantiate one sub-module, sdp_ram_core (simple dual-port RAM, NUM_BANKS*DEPTH words, address {bank, offset}, registered read, optional output stage), holding no control logic.

Verification (DATA_WIDTH=16, DEPTH=8, NUM_BANKS=2, READ_LATENCY=2)
REQ-033 SHALL cover: write 0x0000..0x0007 -> rd_bank_valid high the cycle after the 8th write; rd_req addr 0..7 back-to-back -> rd_valid for 8 cycles starting 2 cycles after the first rd_req, rd_data 0x0000..0x0007.
REQ-034 SHALL cover: write 16 words with no rd_done -> wr_ready low after word 16; a 17th wr_valid -> overflow=1, bank 0 data unchanged on readback.
REQ-035 SHALL cover: 8th write of bank 1 and rd_done of bank 0 in the same cycle -> full_cnt stays 1, rd_bank_valid stays high, next reads return bank 1.
REQ-036 SHALL cover: rd_req addr 5 and rd_done same cycle -> rd_data=0x0005 from the released bank two cycles later.
REQ-037 SHALL cover: rst_n low for one cycle after 3 writes with a read in flight -> rd_valid never asserts for that read, wr_ready=1, rd_bank_valid=0, next write lands at bank 0 address 0.
REQ-038 SHALL cover: rd_req with rd_bank_valid low -> rd_valid stays low for 4 cycles.
